mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single strobe/ready memory port between the instruction cache (I side) and the data cache (D side). Each side presents a held request, and the arbiter grants one side at a time. It muxes the granted side onto the m_* port and returns m_ready and read data only to the granted side. The block sits between both caches and the external memory/bridge interface.

Parameters:
A_WIDTH, 32, address width of all ports.
STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting. Used only when the optional feature is compiled in.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_a  in  A_WIDTH  I-side address
i_din  in  32  I-side write data
i_dout  out  32  I-side read data
i_strobe  in  1  I-side request
i_rw  in  1  I-side direction, 0 read / 1 write
i_wen  in  4  I-side byte enables
i_size  in  2  I-side access size
i_ready  out  1  I-side completion
d_a, d_din, d_dout, d_strobe, d_rw, d_wen, d_size, d_ready  as I side, for the D side
m_a  out  A_WIDTH  memory address
m_din  out  32  memory write data
m_dout  in  32  memory read data
m_strobe  out  1  memory request
m_rw  out  1  memory direction
m_wen  out  4  memory byte enables
m_size  out  2  memory size
m_ready  in  1  memory completion, single-cycle pulse
grant  out  2  one-hot, {d,i}; 00 when idle
busy  out  1  a transaction is outstanding

Behaviour:
- Requester contract: strobe and all request fields stay stable from assertion until the cycle its ready is 1. The arbiter does not latch request fields.
- States:
  - IDLE: grant=00, m_strobe=0.
  - GNT_I / GNT_D: m_* driven combinationally from the granted side's inputs.
- IDLE transitions, evaluated at the clk edge:
  - d_strobe=1 → GNT_D. D has priority, including when both sides request in the same cycle.
  - else i_strobe=1 → GNT_I.
  - else stay in IDLE.
- GNT_x transitions: stay until m_ready=1, then go to IDLE at that edge.
  - Re-arbitration therefore always passes through IDLE, which is one bubble cycle.
  - Minimum request-to-grant latency is 1 cycle.
- Ready and read data return:
  - x_ready = m_ready & granted(x).
  - The non-granted side's ready is forced to 0.
  - x_dout = m_dout for both sides, unconditionally. Data is only meaningful when that side's ready is 1.
- A granted side that drops strobe before m_ready violates the contract. The arbiter still holds the grant until m_ready.
- busy = (state != IDLE).
- Reset values: state IDLE, grant=00, busy=0, m_strobe=0, i_ready=d_ready=0, and the starve counter at 0.
- Reset mid-transaction forces IDLE the next cycle. An m_ready arriving in the reset cycle is ignored.
- m_ready while in IDLE is ignored and not forwarded.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each IDLE→GNT_D transition taken while i_strobe=1.
  - It clears on any IDLE→GNT_I transition, and on an IDLE→GNT_D transition taken with i_strobe=0.
  - When the counter equals STARVE_LIMIT and i_strobe=1, IDLE → GNT_I even if d_strobe=1.
  - The counter saturates at STARVE_LIMIT.
- Undefined: strict D priority; no counter logic is present.

Decomposition:
- Shared package/header: state encodings (ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_D=2'd2), plus the rw encodings RW_READ=0 and RW_WRITE=1.
- The MEM_ARB_STARVE_GUARD_EN macro lives in compile_options.vh.
- One natural sub-module is arb_req_mux, a purely combinational 2:1 request mux (a, din, strobe, rw, wen, size) selected by grant. Everything else stays in the top.

Test Plan:
- Single I read: i_strobe=1, i_a=0x1FC00000, memory returns 0xDEADBEEF after 3 cycles → m_a=0x1FC00000 from cycle 1, i_ready=1 for exactly one cycle, i_dout=0xDEADBEEF, d_ready stays 0, grant=01 then 00.
- Simultaneous requests: I and D strobe in the same cycle (D write 0x12345678, wen=1111) → D granted first, m_rw=1, m_din=0x12345678. After d_ready comes one IDLE bubble, then grant=01 and I completes.
- Back-to-back D: D reissues a new request immediately after each d_ready while I waits.
  - Guard off: I is never granted over 8 transactions.
  - Guard on, STARVE_LIMIT=4: I is granted after the 4th D completion.
- Reset mid-transaction: rst asserted while in GNT_D before m_ready → next cycle grant=00, busy=0, m_strobe=0. A late m_ready pulse produces no i_ready or d_ready.
- Spurious m_ready in IDLE → no ready pulse on either side and the state is unchanged.
- Byte store passthrough: D write with d_wen=0100, d_size=00, d_a=0x00000402 → m_wen=0100, m_size=00, m_a=0x00000402 while granted.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state and direction encodings for the memory bus arbiter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/compile_options.vh
// rtl/compile_options.vh - build options for the memory bus arbiter
// Define MEM_ARB_STARVE_GUARD_EN here to bound consecutive D grants while I waits.
// Left undefined by default: strict D priority.
`ifndef MEM_BUS_ARBITER_COMPILE_OPTIONS_VH
`define MEM_BUS_ARBITER_COMPILE_OPTIONS_VH
// `define MEM_ARB_STARVE_GUARD_EN
`endif

// File: rtl/mem_bus_arbiter_arb_req_mux.sv
// rtl/mem_bus_arbiter_arb_req_mux.sv - combinational 2:1 request mux onto the memory port
module arb_req_mux
  import mem_bus_arbiter_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic [1:0]         grant,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [31:0]        i_din,
  input  logic               i_strobe,
  input  logic               i_rw,
  input  logic [3:0]         i_wen,
  input  logic [1:0]         i_size,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size
);

  // Route the granted side's fields to memory; with no grant the strobe stays low.
  always_comb begin
    m_a      = i_a;
    m_din    = i_din;
    m_strobe = 1'b0;
    m_rw     = RW_READ;
    m_wen    = i_wen;
    m_size   = i_size;
    if (grant[1]) begin
      m_a      = d_a;
      m_din    = d_din;
      m_strobe = d_strobe;
      m_rw     = d_rw;
      m_wen    = d_wen;
      m_size   = d_size;
    end else if (grant[0]) begin
      m_strobe = i_strobe;
      m_rw     = i_rw;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D cache arbiter for the shared memory port (option: MEM_ARB_STARVE_GUARD_EN)
`include "compile_options.vh"

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int A_WIDTH      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [31:0]        i_din,
  output logic [31:0]        i_dout,
  input  logic               i_strobe,
  input  logic               i_rw,
  input  logic [3:0]         i_wen,
  input  logic [1:0]         i_size,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  output logic [31:0]        d_dout,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  input  logic [31:0]        m_dout,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  input  logic               m_ready,
  output logic [1:0]         grant,
  output logic               busy
);

  arb_state_t state_q, state_d;
  logic       starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT)) && i_strobe;

  // Count D grants that overtook a waiting I; any grant with I not waiting restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (state_d == ARB_GNT_I) begin
        starve_cnt <= '0;
      end else if (state_d == ARB_GNT_D) begin
        if (!i_strobe) begin
          starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end
    end
  end
`else
  logic guard_unused;
  assign starve_hit   = 1'b0;
  assign guard_unused = (STARVE_LIMIT != 0);
`endif

  // State register; reset wins over any m_ready seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitrate only from IDLE; hold a grant until memory completes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (starve_hit)    state_d = ARB_GNT_I;
        else if (d_strobe) state_d = ARB_GNT_D;
        else if (i_strobe) state_d = ARB_GNT_I;
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (m_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Decode the one-hot {d,i} grant from the current state.
  always_comb begin
    grant = 2'b00;
    case (state_q)
      ARB_GNT_I: grant = 2'b01;
      ARB_GNT_D: grant = 2'b10;
      default:   grant = 2'b00;
    endcase
  end

  assign busy = (state_q != ARB_IDLE);

  // Completion goes only to the granted side and never during reset.
  assign i_ready = m_ready & grant[0] & ~rst;
  assign d_ready = m_ready & grant[1] & ~rst;
  assign i_dout  = m_dout;
  assign d_dout  = m_dout;

  arb_req_mux #(.A_WIDTH(A_WIDTH)) u_req_mux (
    .grant    (grant),
    .i_a      (i_a),
    .i_din    (i_din),
    .i_strobe (i_strobe),
    .i_rw     (i_rw),
    .i_wen    (i_wen),
    .i_size   (i_size),
    .d_a      (d_a),
    .d_din    (d_din),
    .d_strobe (d_strobe),
    .d_rw     (d_rw),
    .d_wen    (d_wen),
    .d_size   (d_size),
    .m_a      (m_a),
    .m_din    (m_din),
    .m_strobe (m_strobe),
    .m_rw     (m_rw),
    .m_wen    (m_wen),
    .m_size   (m_size)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard bench for the memory bus arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_a, i_din, i_dout, d_a, d_din, d_dout, m_a, m_din, m_dout;
  logic        i_strobe, i_rw, i_ready, d_strobe, d_rw, d_ready;
  logic [3:0]  i_wen, d_wen, m_wen;
  logic [1:0]  i_size, d_size, m_size, grant;
  logic        m_strobe, m_rw, m_ready, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        side;   // 0 = I, 1 = D
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.A_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_din(i_din), .i_dout(i_dout), .i_strobe(i_strobe), .i_rw(i_rw),
    .i_wen(i_wen), .i_size(i_size), .i_ready(i_ready),
    .d_a(d_a), .d_din(d_din), .d_dout(d_dout), .d_strobe(d_strobe), .d_rw(d_rw),
    .d_wen(d_wen), .d_size(d_size), .d_ready(d_ready),
    .m_a(m_a), .m_din(m_din), .m_dout(m_dout), .m_strobe(m_strobe), .m_rw(m_rw),
    .m_wen(m_wen), .m_size(m_size), .m_ready(m_ready),
    .grant(grant), .busy(busy)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h1FC0_0000) return 32'hDEAD_BEEF;
    return addr ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic side, input logic [31:0] addr);
    exp_t e;
    e.side = side;
    e.data = mem_model(addr);
    sb.push_back(e);
  endtask

  // Memory side: complete the current access after lat cycles and score the returned ready/data.
  task automatic respond(input int lat);
    exp_t e;
    repeat (lat) tick();
    m_ready = 1'b1;
    m_dout  = mem_model(m_a);
    #1;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("ready_side", {30'd0, d_ready, i_ready}, e.side ? 32'd2 : 32'd1);
      check("rdata", e.side ? d_dout : i_dout, e.data);
    end
    tick();
    m_ready = 1'b0;
    if (e.side) d_strobe = 1'b0;
    else        i_strobe = 1'b0;
    #1;
    check("grant_after_done", {30'd0, grant}, 32'd0);
  endtask

  task automatic d_req(input logic [31:0] a, input logic rw, input logic [31:0] din,
                       input logic [3:0] wen, input logic [1:0] size);
    d_a = a; d_rw = rw; d_din = din; d_wen = wen; d_size = size; d_strobe = 1'b1;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b1; m_dout = 32'h0;
    i_a = 0; i_din = 0; i_strobe = 0; i_rw = 0; i_wen = 0; i_size = 2'b10;
    d_a = 0; d_din = 0; d_strobe = 0; d_rw = 0; d_wen = 0; d_size = 2'b10;
    repeat (3) tick();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mstrobe", {31'd0, m_strobe}, 32'd0);
    check("rst_ready", {30'd0, d_ready, i_ready}, 32'd0);
    rst = 1'b0; m_ready = 1'b0;
    tick();

    // Single I read
    i_a = 32'h1FC0_0000; i_rw = 1'b0; i_strobe = 1'b1;
    push(1'b0, 32'h1FC0_0000);
    #1;
    check("i_pre_grant", {30'd0, grant}, 32'd0);
    tick();
    check("i_grant", {30'd0, grant}, 32'd1);
    check("i_m_a", m_a, 32'h1FC0_0000);
    check("i_m_strobe", {31'd0, m_strobe}, 32'd1);
    check("i_busy", {31'd0, busy}, 32'd1);
    respond(2);

    // Simultaneous request: D wins, one bubble, then I
    tick();
    d_req(32'h0000_0100, 1'b1, 32'h1234_5678, 4'b1111, 2'b10);
    i_a = 32'h0000_0200; i_rw = 1'b0; i_strobe = 1'b1;
    push(1'b1, 32'h0000_0100);
    push(1'b0, 32'h0000_0200);
    tick();
    check("sim_grant_d", {30'd0, grant}, 32'd2);
    check("sim_m_rw", {31'd0, m_rw}, 32'd1);
    check("sim_m_din", m_din, 32'h1234_5678);
    check("sim_m_a", m_a, 32'h0000_0100);
    respond(1);
    tick();
    check("sim_grant_i", {30'd0, grant}, 32'd1);
    check("sim_i_m_a", m_a, 32'h0000_0200);
    respond(0);

    // Byte store passthrough
    d_req(32'h0000_0402, 1'b1, 32'h00AB_0000, 4'b0100, 2'b00);
    push(1'b1, 32'h0000_0402);
    tick();
    check("bs_grant", {30'd0, grant}, 32'd2);
    check("bs_m_wen", {28'd0, m_wen}, 32'h4);
    check("bs_m_size", {30'd0, m_size}, 32'd0);
    check("bs_m_a", m_a, 32'h0000_0402);
    respond(1);

    // Back-to-back D with I waiting throughout
    i_a = 32'h0000_0300; i_rw = 1'b0; i_strobe = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d_req(32'h0000_1000 + 32'(k) * 4, 1'b0, 32'h0, 4'b0000, 2'b10);
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (k == 4) begin
        push(1'b0, 32'h0000_0300);
        tick();
        check("starve_grant_i", {30'd0, grant}, 32'd1);
        respond(0);
      end
`endif
      push(1'b1, 32'h0000_1000 + 32'(k) * 4);
      tick();
      check("b2b_grant_d", {30'd0, grant}, 32'd2);
      respond(0);
    end
`ifndef MEM_ARB_STARVE_GUARD_EN
    push(1'b0, 32'h0000_0300);
    tick();
    check("b2b_late_grant_i", {30'd0, grant}, 32'd1);
    respond(0);
`endif

    // Reset mid-transaction, m_ready in the reset cycle and afterwards
    d_req(32'h0000_0500, 1'b0, 32'h0, 4'b0000, 2'b10);
    tick();
    check("mid_grant_d", {30'd0, grant}, 32'd2);
    rst = 1'b1; m_ready = 1'b1; m_dout = 32'h5555_AAAA;
    #1;
    check("mid_rst_ready", {30'd0, d_ready, i_ready}, 32'd0);
    tick();
    rst = 1'b0; m_ready = 1'b0; d_strobe = 1'b0;
    #1;
    check("mid_grant", {30'd0, grant}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_mstrobe", {31'd0, m_strobe}, 32'd0);
    m_ready = 1'b1;
    #1;
    check("late_ready", {30'd0, d_ready, i_ready}, 32'd0);
    tick();
    m_ready = 1'b0;
    check("late_grant", {30'd0, grant}, 32'd0);

    // Spurious m_ready in IDLE
    tick();
    m_ready = 1'b1;
    #1;
    check("spur_ready", {30'd0, d_ready, i_ready}, 32'd0);
    tick();
    m_ready = 1'b0;
    check("spur_busy", {31'd0, busy}, 32'd0);
    check("spur_grant", {30'd0, grant}, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
